pacman_step_sequencer: RTL and testbench

//  Turns held direction levels from the keyboard stage into timed one-tile pacman moves.
//  - Reads the map RAM row of the target tile, rejects walls, and presents curr/next pacman coords.
//  - The map RAM writer consumes curr/next; its done pulse commits the move.
//  - Counts pellets eaten. Sits between keyboard_process and the map RAM writer.

---
 rtl/pacman_pkg.sv | 48 ++++
 rtl/pacman_step_sequencer_step_timer.sv | 49 ++++
 rtl/pacman_step_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pacman_step_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
//   Shared types and constants for the pacman step sequencer slice.
//   - tile_t  : 4-bit map tile codes held in the map RAM
//   - dir_t   : latched movement direction
//   - state_t : step sequencer FSM states
//   - tile_at : extracts tile x from a 160-bit map row (tile x at [159-4x -:4])
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package pacman_pkg;

    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;
    localparam int TILE_BITS = 4;

    localparam logic [5:0] MAX_X = 6'd39;
    localparam logic [4:0] MAX_Y = 5'd29;

    typedef enum logic [3:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PELLET = 4'd2,
        PACMAN = 4'd3
    } tile_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CHECK   = 2'd2,
        MOVE    = 2'd3
    } state_t;

    // Tile 0 occupies the most significant nibble of the row word.
    function automatic tile_t tile_at(input logic [159:0] row, input logic [5:0] x);
        logic [7:0] base;
        base = 8'd159 - {x, 2'b00};
        return tile_t'(row[base -: 4]);
    endfunction

endpackage

// File: rtl/pacman_step_sequencer_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
//   Free-running 0..STEP_CYCLES-1 counter. tick is a registered 1-cycle pulse,
//   high during the cycle in which the counter holds its last value.
//   Ports:
//     clk   in   system clock
//     rst_n in   asynchronous active-low reset (counter returns to 0)
//     tick  out  1-cycle pulse at counter wrap
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module step_timer #(
    parameter int STEP_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          tick_r;

    // Next counter value with wrap at LAST.
    always_comb begin
        cnt_next_s = {CW{1'b0}};
        if (cnt_r == LAST) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register; tick is registered so it lines up with cnt_r == LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/pacman_step_sequencer.sv
// -----------------------------------------------------------------------------
// pacman_step_sequencer
//   Turns held direction keys into timed one-tile pacman moves. On each step
//   tick it reads the map row of the target tile, rejects walls / off-map
//   targets, and presents curr/next coords to the map RAM writer. The writer's
//   done pulse commits the move; moves landing on a pellet are counted.
//   Ports:
//     CLOCK_50                in   system clock
//     reset                   in   asynchronous active-low reset
//     up, down, left, right   in   held direction levels (priority up>down>left>right)
//     rd_addr[4:0]            out  map RAM row address
//     rd_data[159:0]          in   map RAM row word (RD_LAT cycles after rd_addr)
//     done                    in   writer pulse: curr->next rewrite complete
//     curr_pacman_x/y         out  committed position
//     next_pacman_x/y         out  target position (next != curr is the writer request)
//     pellet_pulse            out  1-cycle pulse with a commit that ate a pellet
//     pellet_count[9:0]       out  saturating pellets-eaten count
//   Configuration macro: PACMAN_TUNNEL_WRAP_EN (defined: left/right edges wrap;
//   undefined: edges are blocked like walls).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pacman_step_sequencer
    import pacman_pkg::*;
#(
    parameter int STEP_CYCLES = 2_500_000,
    parameter int RD_LAT      = 2,
    parameter int START_X     = 19,
    parameter int START_Y     = 23
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    output logic [4:0]   rd_addr,
    input  logic [159:0] rd_data,
    input  logic         done,
    output logic [5:0]   curr_pacman_x,
    output logic [4:0]   curr_pacman_y,
    output logic [5:0]   next_pacman_x,
    output logic [4:0]   next_pacman_y,
    output logic         pellet_pulse,
    output logic [9:0]   pellet_count
);

    localparam logic [5:0] START_X_C = 6'(START_X);
    localparam logic [4:0] START_Y_C = 5'(START_Y);
    localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 1);

    state_t       state_r, state_s;
    dir_t         dir_r, dir_s;
    logic         tick_s;
    logic [7:0]   wait_cnt_r;
    logic [5:0]   curr_x_r, next_x_r, tgt_x_r, tgt_x_s;
    logic [4:0]   curr_y_r, next_y_r, tgt_y_r, tgt_y_s;
    logic         blocked_r, blocked_s;
    logic         pellet_flag_r;
    logic         pellet_pulse_r;
    logic [9:0]   count_r;
    logic [4:0]   rd_addr_r;
    tile_t        tile_s;
    logic         start_s;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .tick  (tick_s)
    );

    assign start_s = (state_r == IDLE) && tick_s && (dir_r != NONE);
    assign tile_s  = tile_at(rd_data, tgt_x_r);

    // Key priority encode; no key held keeps the current direction.
    always_comb begin
        dir_s = dir_r;
        if (up) begin
            dir_s = UP;
        end else if (down) begin
            dir_s = DOWN;
        end else if (left) begin
            dir_s = LEFT;
        end else if (right) begin
            dir_s = RIGHT;
        end else begin
            dir_s = dir_r;
        end
    end

    // Direction latch register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dir_r <= NONE;
        end else begin
            dir_r <= dir_s;
        end
    end

    // Target tile from the committed position and the latched direction.
    always_comb begin
        tgt_x_s   = curr_x_r;
        tgt_y_s   = curr_y_r;
        blocked_s = 1'b0;
        case (dir_r)
            UP: begin
                if (curr_y_r == 5'd0) begin
                    blocked_s = 1'b1;
                end else begin
                    tgt_y_s = curr_y_r - 5'd1;
                end
            end
            DOWN: begin
                if (curr_y_r >= MAX_Y) begin
                    blocked_s = 1'b1;
                end else begin
                    tgt_y_s = curr_y_r + 5'd1;
                end
            end
            LEFT: begin
                if (curr_x_r == 6'd0) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    tgt_x_s = MAX_X;
`else
                    blocked_s = 1'b1;
`endif
                end else begin
                    tgt_x_s = curr_x_r - 6'd1;
                end
            end
            RIGHT: begin
                if (curr_x_r >= MAX_X) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                    tgt_x_s = 6'd0;
`else
                    blocked_s = 1'b1;
`endif
                end else begin
                    tgt_x_s = curr_x_r + 6'd1;
                end
            end
            default: begin
                blocked_s = 1'b1;
            end
        endcase
    end

    // FSM next-state logic. Ticks outside IDLE are simply not looked at.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (wait_cnt_r >= WAIT_LAST) begin
                    state_s = CHECK;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            CHECK: begin
                if (blocked_r || (tile_s == WALL)) begin
                    state_s = IDLE;
                end else begin
                    state_s = MOVE;
                end
            end
            MOVE: begin
                if (done) begin
                    state_s = IDLE;
                end else begin
                    state_s = MOVE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: target capture, read wait, tile check and move commit.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wait_cnt_r     <= 8'd0;
            tgt_x_r        <= START_X_C;
            tgt_y_r        <= START_Y_C;
            blocked_r      <= 1'b0;
            pellet_flag_r  <= 1'b0;
            curr_x_r       <= START_X_C;
            curr_y_r       <= START_Y_C;
            next_x_r       <= START_X_C;
            next_y_r       <= START_Y_C;
            rd_addr_r      <= START_Y_C;
            pellet_pulse_r <= 1'b0;
            count_r        <= 10'd0;
        end else begin
            pellet_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        tgt_x_r    <= tgt_x_s;
                        tgt_y_r    <= tgt_y_s;
                        blocked_r  <= blocked_s;
                        wait_cnt_r <= 8'd0;
                        // A blocked target may lie off the map; keep the
                        // address on a real row, the result is discarded.
                        rd_addr_r  <= blocked_s ? curr_y_r : tgt_y_s;
                    end
                end
                RD_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                end
                CHECK: begin
                    if (!(blocked_r || (tile_s == WALL))) begin
                        next_x_r      <= tgt_x_r;
                        next_y_r      <= tgt_y_r;
                        pellet_flag_r <= (tile_s == PELLET);
                    end
                end
                MOVE: begin
                    if (done) begin
                        curr_x_r       <= next_x_r;
                        curr_y_r       <= next_y_r;
                        pellet_pulse_r <= pellet_flag_r;
                        if (pellet_flag_r && (count_r != 10'd1023)) begin
                            count_r <= count_r + 10'd1;
                        end
                    end
                end
                default: begin
                    wait_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    assign rd_addr       = rd_addr_r;
    assign curr_pacman_x = curr_x_r;
    assign curr_pacman_y = curr_y_r;
    assign next_pacman_x = next_x_r;
    assign next_pacman_y = next_y_r;
    assign pellet_pulse  = pellet_pulse_r;
    assign pellet_count  = count_r;

endmodule

// File: tb/tb_pacman_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pacman_step_sequencer
//   Bench for pacman_step_sequencer with a short step period. Models the map
//   RAM (2-cycle read latency) and the map RAM writer (done a fixed number of
//   cycles after a request). A commit monitor pops expected moves from a
//   scoreboard queue; scenario tasks check timing and state inline.
//   Honours PACMAN_TUNNEL_WRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pacman_step_sequencer;
    import pacman_pkg::*;

    localparam int STEP = 20;
    localparam int RDL  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         k_up = 1'b0, k_down = 1'b0, k_left = 1'b0, k_right = 1'b0;
    logic [4:0]   rd_addr;
    logic [159:0] rd_data = '0;
    logic         done = 1'b0;
    logic [5:0]   curr_x, next_x;
    logic [4:0]   curr_y, next_y;
    logic         pellet_pulse;
    logic [9:0]   pellet_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int wr_delay = 5;
    bit wr_busy = 1'b0;

    logic [159:0] map_mem [0:29];
    logic [159:0] stage1 = '0;
    logic [11:0]  exp_q [$];

    always #10 clk = ~clk;

    pacman_step_sequencer #(
        .STEP_CYCLES(STEP),
        .RD_LAT     (RDL),
        .START_X    (19),
        .START_Y    (23)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst_n),
        .up            (k_up),
        .down          (k_down),
        .left          (k_left),
        .right         (k_right),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .done          (done),
        .curr_pacman_x (curr_x),
        .curr_pacman_y (curr_y),
        .next_pacman_x (next_x),
        .next_pacman_y (next_y),
        .pellet_pulse  (pellet_pulse),
        .pellet_count  (pellet_count)
    );

    // Map RAM model: two register stages from rd_addr to rd_data.
    always @(posedge clk) begin
        stage1  <= (rd_addr < 5'd30) ? map_mem[rd_addr] : '0;
        rd_data <= stage1;
    end

    // Cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Writer model: done pulse wr_delay cycles after a request is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ((next_x != curr_x) || (next_y != curr_y))) begin
                wr_busy = 1'b1;
                repeat (wr_delay) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
                wr_busy = 1'b0;
            end
        end
    end

    // Commit monitor: every change of curr outside reset pops the scoreboard.
    initial begin : monitor
        logic [5:0]  prev_x;
        logic [4:0]  prev_y;
        logic [11:0] e;
        prev_x = 6'd19;
        prev_y = 5'd23;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_x = curr_x;
                prev_y = curr_y;
            end else if ((curr_x != prev_x) || (curr_y != prev_y)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL commit_unexpected: got (%0d,%0d) pulse=%0b, none expected", curr_x, curr_y, pellet_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if ({curr_x, curr_y, pellet_pulse} !== e) begin
                        n_bad++;
                        $display("FAIL commit: got (%0d,%0d) pulse=%0b, want (%0d,%0d) pulse=%0b",
                                 curr_x, curr_y, pellet_pulse, e[11:6], e[5:1], e[0]);
                    end
                end
                prev_x = curr_x;
                prev_y = curr_y;
            end else if (pellet_pulse) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pellet_pulse_spurious: pulse=1 with no commit at (%0d,%0d)", curr_x, curr_y);
            end
        end
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    task automatic clear_map();
        for (int r = 0; r < 30; r++) map_mem[r] = '0;
    endtask

    task automatic set_tile(input int y, input int x, input tile_t t);
        logic [159:0] row;
        row = map_mem[y];
        row[159-4*x -: 4] = t;
        map_mem[y] = row;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // keys = {up, down, left, right}; release happens on a negedge.
    task automatic do_reset(input logic [3:0] keys);
        int guard;
        @(negedge clk);
        rst_n = 1'b0;
        {k_up, k_down, k_left, k_right} = 4'b0000;
        repeat (3) @(negedge clk);
        guard = 0;
        while (wr_busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (wr_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL writer_idle: busy=1 after %0d cycles, want 0", guard);
        end
        exp_q.delete();
        {k_up, k_down, k_left, k_right} = keys;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_map();
        do_reset(4'b0000);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y} !== {6'd19, 5'd23, 6'd19, 5'd23}) begin
            n_bad++;
            $display("FAIL reset_pos: curr=(%0d,%0d) next=(%0d,%0d), want (19,23)/(19,23)", curr_x, curr_y, next_x, next_y);
        end
        n_cmp++;
        if (rd_addr !== 5'd23) begin
            n_bad++;
            $display("FAIL reset_rd_addr: got %0d, want 23", rd_addr);
        end
        n_cmp++;
        if ({pellet_count, pellet_pulse} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_pellet: count=%0d pulse=%0b, want 0/0", pellet_count, pellet_pulse);
        end
        wait_cyc(3*STEP + 5);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y} !== {6'd19, 5'd23, 6'd19, 5'd23}) begin
            n_bad++;
            $display("FAIL idle_no_keys: curr=(%0d,%0d) next=(%0d,%0d), want (19,23)/(19,23)", curr_x, curr_y, next_x, next_y);
        end
        n_cmp++;
        if ({rd_addr, pellet_count} !== {5'd23, 10'd0}) begin
            n_bad++;
            $display("FAIL idle_rd_count: rd_addr=%0d count=%0d, want 23/0", rd_addr, pellet_count);
        end
    endtask

    task automatic test_step_right();
        clear_map();
        wr_delay = 5;
        do_reset(4'b0001);
        exp_q.push_back({6'd20, 5'd23, 1'b0});
        // First tick in cycle STEP-1; next valid RD_LAT+2 cycles later.
        wait_cyc(STEP - 1 + RDL + 1);
        n_cmp++;
        if ({next_x, next_y} !== {6'd19, 5'd23}) begin
            n_bad++;
            $display("FAIL right_next_early: next=(%0d,%0d), want (19,23)", next_x, next_y);
        end
        wait_cyc(STEP - 1 + RDL + 2);
        n_cmp++;
        if ({next_x, next_y} !== {6'd20, 5'd23}) begin
            n_bad++;
            $display("FAIL right_next_latency: next=(%0d,%0d), want (20,23)", next_x, next_y);
        end
        wait_cyc(STEP - 1 + RDL + 2 + 5);
        n_cmp++;
        if ({curr_x, curr_y} !== {6'd19, 5'd23}) begin
            n_bad++;
            $display("FAIL right_curr_before_done: curr=(%0d,%0d), want (19,23)", curr_x, curr_y);
        end
        wait_cyc(STEP - 1 + RDL + 2 + 6);
        n_cmp++;
        if ({curr_x, curr_y, pellet_count} !== {6'd20, 5'd23, 10'd0}) begin
            n_bad++;
            $display("FAIL right_commit: curr=(%0d,%0d) count=%0d, want (20,23)/0", curr_x, curr_y, pellet_count);
        end
        wait_cyc(STEP - 1 + RDL + 8);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL right_scoreboard: %0d moves pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_wall_up();
        clear_map();
        set_tile(22, 19, WALL);
        wr_delay = 5;
        do_reset(4'b1000);
        wait_cyc(STEP + 1);
        n_cmp++;
        if (rd_addr !== 5'd22) begin
            n_bad++;
            $display("FAIL wall_rd_addr: got %0d, want 22", rd_addr);
        end
        wait_cyc(STEP + 15);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y} !== {6'd19, 5'd23, 6'd19, 5'd23}) begin
            n_bad++;
            $display("FAIL wall_blocked: curr=(%0d,%0d) next=(%0d,%0d), want (19,23)/(19,23)", curr_x, curr_y, next_x, next_y);
        end
        n_cmp++;
        if ({pellet_count, wr_busy} !== {10'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL wall_no_request: count=%0d writer_busy=%0b, want 0/0", pellet_count, wr_busy);
        end
    endtask

    task automatic test_edge_left();
        logic [5:0] want_x;
        logic [9:0] want_cnt;
        clear_map();
        set_tile(23, 39, PELLET);
        set_tile(23, 38, WALL);
        wr_delay = 5;
        do_reset(4'b0010);
        for (int x = 18; x >= 0; x--) exp_q.push_back({6'(x), 5'd23, 1'b0});
`ifdef PACMAN_TUNNEL_WRAP_EN
        exp_q.push_back({6'd39, 5'd23, 1'b1});
        want_x   = 6'd39;
        want_cnt = 10'd1;
`else
        want_x   = 6'd0;
        want_cnt = 10'd0;
`endif
        // Tick 20 is the attempt from x=0.
        wait_cyc(20*STEP - 1 + RDL + 2);
        n_cmp++;
        if ({next_x, next_y} !== {want_x, 5'd23}) begin
            n_bad++;
            $display("FAIL edge_next: next=(%0d,%0d), want (%0d,23)", next_x, next_y, want_x);
        end
        wait_cyc(22*STEP);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y} !== {want_x, 5'd23, want_x, 5'd23}) begin
            n_bad++;
            $display("FAIL edge_final: curr=(%0d,%0d) next=(%0d,%0d), want (%0d,23)", curr_x, curr_y, next_x, next_y, want_x);
        end
        n_cmp++;
        if (pellet_count !== want_cnt) begin
            n_bad++;
            $display("FAIL edge_count: got %0d, want %0d", pellet_count, want_cnt);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL edge_scoreboard: %0d moves pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_priority_drop();
        clear_map();
        wr_delay = 30;
        do_reset(4'b1010);
        exp_q.push_back({6'd19, 5'd22, 1'b0});
        wait_cyc(STEP - 1 + RDL + 2);
        n_cmp++;
        if ({next_x, next_y} !== {6'd19, 5'd22}) begin
            n_bad++;
            $display("FAIL priority_up: next=(%0d,%0d), want (19,22)", next_x, next_y);
        end
        // Second tick (cycle 2*STEP-1) lands in MOVE.
        wait_cyc(2*STEP + 5);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y} !== {6'd19, 5'd23, 6'd19, 5'd22}) begin
            n_bad++;
            $display("FAIL move_hold: curr=(%0d,%0d) next=(%0d,%0d), want (19,23)/(19,22)", curr_x, curr_y, next_x, next_y);
        end
        wait_cyc(STEP - 1 + RDL + 2 + 31);
        n_cmp++;
        if ({curr_x, curr_y} !== {6'd19, 5'd22}) begin
            n_bad++;
            $display("FAIL one_move_commit: curr=(%0d,%0d), want (19,22)", curr_x, curr_y);
        end
        wait_cyc(3*STEP - 2);
        n_cmp++;
        if ({next_x, next_y} !== {6'd19, 5'd22}) begin
            n_bad++;
            $display("FAIL tick_dropped: next=(%0d,%0d), want (19,22)", next_x, next_y);
        end
        wait_cyc(3*STEP - 1 + RDL + 2);
        n_cmp++;
        if ({next_x, next_y} !== {6'd19, 5'd21}) begin
            n_bad++;
            $display("FAIL next_tick_moves: next=(%0d,%0d), want (19,21)", next_x, next_y);
        end
        wr_delay = 5;
    endtask

    task automatic test_reset_in_move();
        clear_map();
        wr_delay = 5;
        do_reset(4'b0001);
        wait_cyc(STEP - 1 + RDL + 2);
        n_cmp++;
        if ({next_x, next_y} !== {6'd20, 5'd23}) begin
            n_bad++;
            $display("FAIL rim_request: next=(%0d,%0d), want (20,23)", next_x, next_y);
        end
        wait_cyc(STEP - 1 + RDL + 4);
        rst_n = 1'b0;
        k_right = 1'b0;
        #1;
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y, rd_addr} !== {6'd19, 5'd23, 6'd19, 5'd23, 5'd23}) begin
            n_bad++;
            $display("FAIL rim_async: curr=(%0d,%0d) next=(%0d,%0d) rd_addr=%0d, want (19,23)/(19,23)/23",
                     curr_x, curr_y, next_x, next_y, rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // The writer's pending done arrives after release and must be ignored.
        wait_cyc(10);
        n_cmp++;
        if ({curr_x, curr_y, next_x, next_y, pellet_count} !== {6'd19, 5'd23, 6'd19, 5'd23, 10'd0}) begin
            n_bad++;
            $display("FAIL rim_stray_done: curr=(%0d,%0d) next=(%0d,%0d) count=%0d, want (19,23)/(19,23)/0",
                     curr_x, curr_y, next_x, next_y, pellet_count);
        end
    endtask

    initial begin
        clear_map();
        test_reset();
        test_step_right();
        test_wall_up();
        test_edge_left();
        test_priority_drop();
        test_reset_in_move();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
